axi_lite_master_if: RTL
=======================

# axi_lite_master_if

AXI-Lite initiator that is the master-side counterpart of the team's AXI slave interface. It accepts single-beat read/write commands from internal logic on a valid/ready command port, drives the AW/W/B or AR/R channel handshakes, and returns one response per command on a valid/ready response port. It allows one outstanding transaction at a time and sits between a local controller (DMA, config sequencer) and the AXI fabric.

## Interface

**Parameters**

- `DATA_WIDTH`, 32, data bus width; a multiple of 8.
- `ADDR_WIDTH`, 32, address width.
- `TIMEOUT_CYCLES`, 256, watchdog limit in cycles; only used when `AXI_MASTER_TIMEOUT_EN` is defined; range 1..65535.

**Ports**

- `i_axi_clk` in 1: the single clock.
- `i_axi_rst_n` in 1: reset, asynchronous assert, active-low.
- `i_cmd_valid` in 1 / `o_cmd_ready` out 1: command handshake.
- `i_cmd_write` in 1: 1 = write, 0 = read.
- `i_cmd_addr` in ADDR_WIDTH: command address.
- `i_cmd_wdata` in DATA_WIDTH / `i_cmd_wstrb` in DATA_WIDTH/8: write payload; ignored for reads.
- `o_rsp_valid` out 1 / `i_rsp_ready` in 1: response handshake.
- `o_rsp_write` out 1: echoes `i_cmd_write` of the completed command.
- `o_rsp_rdata` out DATA_WIDTH / `o_rsp_rstrb` out DATA_WIDTH/8: read data and strobe; 0 for writes.
- `o_rsp_resp` out 2: captured `bresp` for writes; 2'b00 for reads; 2'b11 on timeout.
- `o_axi_awvalid` out 1, `i_axi_awready` in 1, `o_axi_awaddr` out ADDR_WIDTH.
- `o_axi_wvalid` out 1, `i_axi_wready` in 1, `o_axi_wdata` out DATA_WIDTH, `o_axi_wstrb` out DATA_WIDTH/8.
- `i_axi_bvalid` in 1, `o_axi_bready` out 1, `i_axi_bresp` in 2.
- `o_axi_arvalid` out 1, `i_axi_arready` in 1, `o_axi_araddr` out ADDR_WIDTH.
- `i_axi_rvalid` in 1, `o_axi_rready` out 1, `i_axi_rdata` in DATA_WIDTH, `i_axi_rstrb` in DATA_WIDTH/8.
- `o_timeout` out 1: sticky watchdog flag.

## Operation

- **States:** IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP, plus HUNG when the timeout feature is compiled in.
- **Reset values:** every output is 0 after reset, except `o_cmd_ready`, which is 1. The FSM resets to IDLE.
- **IDLE:**
  - `o_cmd_ready` = 1, and it is asserted only in IDLE.
  - On a command handshake, the block registers addr/wdata/wstrb/write.
  - Write commands go to WR_REQ with `awvalid` = `wvalid` = 1. Read commands go to RD_REQ with `arvalid` = 1.
- **WR_REQ:**
  - AW and W are independent. Each valid drops in the cycle after its own handshake.
  - A `done` flag is kept per channel.
  - When both channels are done (including the same cycle), the FSM goes to WR_RESP with `bready` = 1.
- **WR_RESP:**
  - On `bvalid & bready`, the block captures `bresp`, drops `bready`, and goes to RSP.
- **RD_REQ:**
  - On `arvalid & arready`, the block drops `arvalid`, sets `rready` = 1, and goes to RD_RESP.
- **RD_RESP:**
  - On `rvalid & rready`, the block captures `rdata`/`rstrb`, drops `rready`, and goes to RSP.
- **RSP:**
  - `o_rsp_valid` = 1, and response fields are held stable until `i_rsp_ready`. The FSM then returns to IDLE.
- **AXI outputs:** every AXI valid and ready output is a flop. No valid is ever withdrawn before its handshake completes.
- **Stability:** AXI address/data outputs are stable while their valid is high.
- **Asynchronous reset mid-transaction:** all state and outputs return to reset values immediately. No response is generated for the aborted command.

## Timing

- Command accepted at cycle 0 → AW/W/AR valid at cycle 1.
- **Best-case write:** `awready`/`wready` high at cycle 1, WR_RESP at cycle 2, `bvalid` at cycle 2, `o_rsp_valid` at cycle 3.
- **Best-case read:** `arready` high at cycle 1, `rvalid` at cycle 2, `o_rsp_valid` at cycle 3.
- `o_cmd_ready` returns to 1 in the cycle after the response handshake.
- Back-to-back commands: the minimum spacing is 4 cycles.

## Configuration

`AXI_MASTER_TIMEOUT_EN`

- **Defined:**
  - A 16-bit counter clears on entry to WR_REQ/RD_REQ and on every AXI handshake. It increments in all other cycles spent in WR_REQ, WR_RESP, RD_REQ and RD_RESP.
  - When the counter reaches `TIMEOUT_CYCLES`, the block:
    - sets `o_timeout` = 1, which is sticky until reset;
    - goes to RSP with resp 2'b11 and rdata/rstrb = 0;
    - after the response handshake, goes to HUNG.
  - **HUNG:**
    - `o_cmd_ready` = 0 until reset.
    - Pending AXI valids stay asserted until their handshake, then drop.
    - Late B/R beats are accepted (`bready`/`rready` = 1) and discarded.
- **Not defined:**
  - There is no counter and no HUNG state; `o_timeout` is tied to 0.
  - The FSM waits indefinitely.

## Test plan

- **Write, channels aligned:** addr 0x10, data 0xDEADBEEF, strb 0xF; slave ready on AW and W at cycle 1, `bresp` 00 at cycle 2 → `o_rsp_valid` at cycle 3 with resp 00, write = 1, rdata 0.
- **Write, W before AW:** `wready` at cycle 1, `awready` at cycle 4 → `wvalid` low from cycle 2, `awvalid` held until cycle 4, `bready` at cycle 5; `bresp` 10 → `o_rsp_resp` 10.
- **Read with R stall and response backpressure:** read 0x24; `arready` at cycle 3; `rvalid` at cycle 6 with 0x12345678/strb 0xF; `i_rsp_ready` low for 3 cycles → response held stable, then `o_cmd_ready` = 1 the cycle after the handshake.
- **Reset mid-write:** assert `i_axi_rst_n` low during WR_RESP → all valids/readies 0 asynchronously, `o_cmd_ready` = 1 after release, no response emitted.
- **Timeout (macro defined, `TIMEOUT_CYCLES` = 8):** read with `arready` stuck low → `o_timeout` = 1 and `o_rsp_resp` = 11 after 8 cycles, `arvalid` held; after the response handshake `o_cmd_ready` stays 0.
- **Macro undefined, same stimulus:** `o_timeout` stays 0 and no response is produced.

Source files
------------

// File: rtl/axi_lite_master_if.sv
// axi_lite_master_if: single-outstanding AXI-Lite initiator. Takes one read or
// write command on a valid/ready port, runs the AW/W/B or AR/R handshakes and
// returns one response per command on a valid/ready response port.
// Optional feature macro: AXI_MASTER_TIMEOUT_EN (watchdog counter + HUNG state).
module axi_lite_master_if #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                      i_axi_clk,
  input  logic                      i_axi_rst_n,
  input  logic                      i_cmd_valid,
  output logic                      o_cmd_ready,
  input  logic                      i_cmd_write,
  input  logic [ADDR_WIDTH-1:0]     i_cmd_addr,
  input  logic [DATA_WIDTH-1:0]     i_cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0]   i_cmd_wstrb,
  output logic                      o_rsp_valid,
  input  logic                      i_rsp_ready,
  output logic                      o_rsp_write,
  output logic [DATA_WIDTH-1:0]     o_rsp_rdata,
  output logic [DATA_WIDTH/8-1:0]   o_rsp_rstrb,
  output logic [1:0]                o_rsp_resp,
  output logic                      o_axi_awvalid,
  input  logic                      i_axi_awready,
  output logic [ADDR_WIDTH-1:0]     o_axi_awaddr,
  output logic                      o_axi_wvalid,
  input  logic                      i_axi_wready,
  output logic [DATA_WIDTH-1:0]     o_axi_wdata,
  output logic [DATA_WIDTH/8-1:0]   o_axi_wstrb,
  input  logic                      i_axi_bvalid,
  output logic                      o_axi_bready,
  input  logic [1:0]                i_axi_bresp,
  output logic                      o_axi_arvalid,
  input  logic                      i_axi_arready,
  output logic [ADDR_WIDTH-1:0]     o_axi_araddr,
  input  logic                      i_axi_rvalid,
  output logic                      o_axi_rready,
  input  logic [DATA_WIDTH-1:0]     i_axi_rdata,
  input  logic [DATA_WIDTH/8-1:0]   i_axi_rstrb,
  output logic                      o_timeout
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  // Elaboration-time parameter sanity checks
  if ((DATA_WIDTH == 0) || ((DATA_WIDTH % 8) != 0)) begin : g_bad_data_width
    $error("axi_lite_master_if: DATA_WIDTH must be a non-zero multiple of 8");
  end
  if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 65535)) begin : g_bad_timeout
    $error("axi_lite_master_if: TIMEOUT_CYCLES must be in 1..65535");
  end

`ifdef AXI_MASTER_TIMEOUT_EN
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_REQ  = 3'd1,
    S_WR_RESP = 3'd2,
    S_RD_REQ  = 3'd3,
    S_RD_RESP = 3'd4,
    S_RSP     = 3'd5,
    S_HUNG    = 3'd6
  } state_t;
  localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES);
`else
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_REQ  = 3'd1,
    S_WR_RESP = 3'd2,
    S_RD_REQ  = 3'd3,
    S_RD_RESP = 3'd4,
    S_RSP     = 3'd5
  } state_t;
`endif

  state_t                  r_state, w_state_nxt;

  logic                    r_cmd_ready, w_cmd_ready_nxt;
  logic                    r_awvalid, w_awvalid_nxt;
  logic                    r_wvalid, w_wvalid_nxt;
  logic                    r_bready, w_bready_nxt;
  logic                    r_arvalid, w_arvalid_nxt;
  logic                    r_rready, w_rready_nxt;
  logic                    r_aw_done, w_aw_done_nxt;
  logic                    r_w_done, w_w_done_nxt;
  logic                    r_rsp_valid, w_rsp_valid_nxt;
  logic [DATA_WIDTH-1:0]   r_rsp_rdata, w_rsp_rdata_nxt;
  logic [STRB_WIDTH-1:0]   r_rsp_rstrb, w_rsp_rstrb_nxt;
  logic [1:0]              r_rsp_resp, w_rsp_resp_nxt;
  logic                    w_cap_cmd;

  logic                    r_write;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [STRB_WIDTH-1:0]   r_wstrb;

`ifdef AXI_MASTER_TIMEOUT_EN
  logic [15:0]             r_cnt, w_cnt_nxt;
  logic                    r_timeout, w_timeout_nxt;
  logic                    w_any_hs;
  logic                    w_busy;
`endif

  // State register
  always_ff @(posedge i_axi_clk or negedge i_axi_rst_n) begin
    if (!i_axi_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and next-output logic; each valid/ready drops after its own handshake
  always_comb begin
    w_state_nxt     = r_state;
    w_awvalid_nxt   = r_awvalid & ~i_axi_awready;
    w_wvalid_nxt    = r_wvalid & ~i_axi_wready;
    w_arvalid_nxt   = r_arvalid & ~i_axi_arready;
    w_bready_nxt    = r_bready & ~i_axi_bvalid;
    w_rready_nxt    = r_rready & ~i_axi_rvalid;
    w_aw_done_nxt   = r_aw_done | (r_awvalid & i_axi_awready);
    w_w_done_nxt    = r_w_done | (r_wvalid & i_axi_wready);
    w_rsp_rdata_nxt = r_rsp_rdata;
    w_rsp_rstrb_nxt = r_rsp_rstrb;
    w_rsp_resp_nxt  = r_rsp_resp;
    w_cap_cmd       = 1'b0;
`ifdef AXI_MASTER_TIMEOUT_EN
    w_cnt_nxt       = r_cnt;
    w_timeout_nxt   = r_timeout;
`endif

    case (r_state)
      S_IDLE: begin
        if (i_cmd_valid) begin
          w_cap_cmd = 1'b1;
          if (i_cmd_write) begin
            w_state_nxt   = S_WR_REQ;
            w_awvalid_nxt = 1'b1;
            w_wvalid_nxt  = 1'b1;
            w_aw_done_nxt = 1'b0;
            w_w_done_nxt  = 1'b0;
          end else begin
            w_state_nxt   = S_RD_REQ;
            w_arvalid_nxt = 1'b1;
          end
        end
      end
      S_WR_REQ: begin
        if (w_aw_done_nxt && w_w_done_nxt) begin
          w_state_nxt  = S_WR_RESP;
          w_bready_nxt = 1'b1;
        end
      end
      S_WR_RESP: begin
        if (r_bready && i_axi_bvalid) begin
          w_state_nxt     = S_RSP;
          w_rsp_resp_nxt  = i_axi_bresp;
          w_rsp_rdata_nxt = '0;
          w_rsp_rstrb_nxt = '0;
        end
      end
      S_RD_REQ: begin
        if (r_arvalid && i_axi_arready) begin
          w_state_nxt  = S_RD_RESP;
          w_rready_nxt = 1'b1;
        end
      end
      S_RD_RESP: begin
        if (r_rready && i_axi_rvalid) begin
          w_state_nxt     = S_RSP;
          w_rsp_rdata_nxt = i_axi_rdata;
          w_rsp_rstrb_nxt = i_axi_rstrb;
          w_rsp_resp_nxt  = 2'b00;
        end
      end
      S_RSP: begin
        if (i_rsp_ready) begin
`ifdef AXI_MASTER_TIMEOUT_EN
          w_state_nxt = r_timeout ? S_HUNG : S_IDLE;
`else
          w_state_nxt = S_IDLE;
`endif
        end
      end
`ifdef AXI_MASTER_TIMEOUT_EN
      S_HUNG: begin
        // Swallow any late B/R beats; pending AW/W/AR valids drain via the defaults
        w_bready_nxt = 1'b1;
        w_rready_nxt = 1'b1;
      end
`endif
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

`ifdef AXI_MASTER_TIMEOUT_EN
    // Watchdog: any handshake restarts the count; reaching the limit forces an error response
    w_any_hs = (r_awvalid & i_axi_awready) | (r_wvalid & i_axi_wready) |
               (r_bready & i_axi_bvalid) | (r_arvalid & i_axi_arready) |
               (r_rready & i_axi_rvalid);
    w_busy   = (r_state == S_WR_REQ) || (r_state == S_WR_RESP) ||
               (r_state == S_RD_REQ) || (r_state == S_RD_RESP);
    if (!w_busy || w_any_hs) begin
      w_cnt_nxt = 16'd0;
    end else if ((r_cnt + 16'd1) == TO_LIMIT) begin
      w_cnt_nxt       = 16'd0;
      w_timeout_nxt   = 1'b1;
      w_state_nxt     = S_RSP;
      w_rsp_resp_nxt  = 2'b11;
      w_rsp_rdata_nxt = '0;
      w_rsp_rstrb_nxt = '0;
    end else begin
      w_cnt_nxt = r_cnt + 16'd1;
    end
`endif

    w_cmd_ready_nxt = (w_state_nxt == S_IDLE);
    w_rsp_valid_nxt = (w_state_nxt == S_RSP);
  end

  // Registered outputs, handshake flags and captured command
  always_ff @(posedge i_axi_clk or negedge i_axi_rst_n) begin
    if (!i_axi_rst_n) begin
      r_cmd_ready <= 1'b1;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_rstrb <= '0;
      r_rsp_resp  <= 2'b00;
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
    end else begin
      r_cmd_ready <= w_cmd_ready_nxt;
      r_awvalid   <= w_awvalid_nxt;
      r_wvalid    <= w_wvalid_nxt;
      r_bready    <= w_bready_nxt;
      r_arvalid   <= w_arvalid_nxt;
      r_rready    <= w_rready_nxt;
      r_aw_done   <= w_aw_done_nxt;
      r_w_done    <= w_w_done_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_rsp_rstrb <= w_rsp_rstrb_nxt;
      r_rsp_resp  <= w_rsp_resp_nxt;
      if (w_cap_cmd) begin
        r_write <= i_cmd_write;
        r_addr  <= i_cmd_addr;
        r_wdata <= i_cmd_wdata;
        r_wstrb <= i_cmd_wstrb;
      end
    end
  end

`ifdef AXI_MASTER_TIMEOUT_EN
  // Watchdog counter and sticky timeout flag
  always_ff @(posedge i_axi_clk or negedge i_axi_rst_n) begin
    if (!i_axi_rst_n) begin
      r_cnt     <= 16'd0;
      r_timeout <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end
  assign o_timeout = r_timeout;
`else
  assign o_timeout = 1'b0;
`endif

  assign o_cmd_ready   = r_cmd_ready;
  assign o_rsp_valid   = r_rsp_valid;
  assign o_rsp_write   = r_write;
  assign o_rsp_rdata   = r_rsp_rdata;
  assign o_rsp_rstrb   = r_rsp_rstrb;
  assign o_rsp_resp    = r_rsp_resp;
  assign o_axi_awvalid = r_awvalid;
  assign o_axi_awaddr  = r_addr;
  assign o_axi_wvalid  = r_wvalid;
  assign o_axi_wdata   = r_wdata;
  assign o_axi_wstrb   = r_wstrb;
  assign o_axi_bready  = r_bready;
  assign o_axi_arvalid = r_arvalid;
  assign o_axi_araddr  = r_addr;
  assign o_axi_rready  = r_rready;

endmodule
